ifu_fetch: RTL

- Instruction fetch unit for the single-cycle RV32I core.
- Sits directly upstream of decode/control. It holds the PC, fetches each instruction over a req/gnt/rvalid handshake and presents it to decode.
- While an instruction is valid, it consumes the decode outputs jmp_en/jmpr_en/jmpb_en, plus the rs1 data and the immediate, to form the next PC.
- One instruction is in flight at a time; there is no prefetch.

---
 rtl/ifu_fetch.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, fetches one instruction at a time over req/gnt/rvalid
// and computes the next PC on retire. Optional misaligned-target trap via IFU_MISALIGN_TRAP_EN.
module ifu_fetch #(
  parameter int unsigned         XLEN     = 32,
  parameter logic [XLEN-1:0]     RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            jmp_en,
  input  logic            jmpr_en,
  input  logic            jmpb_en,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] data_rs1,
  input  logic            inst_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
`ifdef IFU_MISALIGN_TRAP_EN
  output logic            misalign_err,
`endif
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4
);

  localparam logic [XLEN-1:0] NOP_INST = XLEN'(32'h0000_0013);

`ifdef IFU_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_HALT} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            valid_q, valid_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] target;
`ifdef IFU_MISALIGN_TRAP_EN
  logic            err_q, err_d;
`endif

  // Branch/jump target; JALR has priority over JAL and taken conditional branches.
  always_comb begin
    if (jmpr_en) begin
      target = (data_rs1 + imm) & ~XLEN'(1);
    end else if (jmp_en || jmpb_en) begin
      target = pc_q + imm;
    end else begin
      target = pc_q + XLEN'(4);
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    req_d   = req_q;
`ifdef IFU_MISALIGN_TRAP_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        req_d   = 1'b1;
      end
      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
          req_d   = 1'b0;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          inst_d  = imem_rdata;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!inst_stall) begin
          valid_d = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
          pc_d = target;
          if (target[1]) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end else begin
            state_d = S_REQ;
            req_d   = 1'b1;
          end
`else
          // Without the trap, the fetch address is kept word aligned.
          pc_d    = {target[XLEN-1:2], 2'b00};
          state_d = S_REQ;
          req_d   = 1'b1;
`endif
        end
      end
`ifdef IFU_MISALIGN_TRAP_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      req_q   <= req_d;
`ifdef IFU_MISALIGN_TRAP_EN
      err_q   <= err_d;
`endif
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign pc         = pc_q;
  assign pc_plus4   = pc_q + XLEN'(4);
`ifdef IFU_MISALIGN_TRAP_EN
  assign misalign_err = err_q;
`endif

endmodule
